// File: rtl/instruction_memory_loader.sv
// Instruction memory with registered fetch and a UART byte-serial program loader.
// Define CHECKSUM_EN to add a trailing XOR checksum byte and the sticky load_error flag.
module instruction_memory_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] NOP_WORD   = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           Address,
    input  logic                  rd_en,
    output logic [31:0]           Instruction,
    output logic                  fetch_fault,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam int unsigned         DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
`ifdef CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    logic [31:0]           mem [DEPTH];
    state_t                state_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   ptr_q;
    logic [1:0]            bcnt_q;
    logic [23:0]           word_q;
    logic [31:0]           instr_q;
    logic                  fault_q;
    logic                  rx_ready_q;
    logic                  cpu_hold_q;
    logic                  load_done_q;
`ifdef CHECKSUM_EN
    logic [7:0]            csum_q;
    logic                  load_error_q;
`endif

    logic                  xfer;
    logic [31:0]           word_d;
    logic [ADDR_WIDTH:0]   len_d;
    logic                  last_word;
    logic                  mem_we;
    logic                  addr_ok;
    logic [ADDR_WIDTH-1:0] idx;

    always_comb begin
        xfer      = rx_valid & rx_ready_q;
        word_d    = {word_q, rx_data};
        len_d     = (load_len > DEPTH_W) ? DEPTH_W : load_len;
        last_word = ((ptr_q + ONE_W) == len_q);
        mem_we    = !reset && (state_q == S_LOAD) && xfer && (bcnt_q == 2'd3);
        addr_ok   = (Address[31:ADDR_WIDTH+2] == '0) && (Address[1:0] == 2'b00);
        idx       = Address[ADDR_WIDTH+1:2];
    end

    // Storage is deliberately left out of reset so downloaded programs survive a CPU reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q[ADDR_WIDTH-1:0]] <= word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cpu_hold_q) begin
            instr_q <= NOP_WORD;
            fault_q <= 1'b0;
        end else if (rd_en) begin
            if (addr_ok) begin
                instr_q <= mem[idx];
                fault_q <= 1'b0;
            end else begin
                instr_q <= NOP_WORD;
                fault_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            ptr_q       <= '0;
            bcnt_q      <= '0;
            word_q      <= '0;
            rx_ready_q  <= 1'b0;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b0;
`ifdef CHECKSUM_EN
            csum_q       <= '0;
            load_error_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_start && (load_len != '0)) begin
                        state_q    <= S_LOAD;
                        len_q      <= len_d;
                        ptr_q      <= '0;
                        bcnt_q     <= '0;
                        rx_ready_q <= 1'b1;
                        cpu_hold_q <= 1'b1;
`ifdef CHECKSUM_EN
                        csum_q       <= '0;
                        load_error_q <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        word_q <= word_d[23:0];
                        bcnt_q <= bcnt_q + 2'd1;
`ifdef CHECKSUM_EN
                        csum_q <= csum_q ^ rx_data;
`endif
                        if (bcnt_q == 2'd3) begin
                            ptr_q <= ptr_q + ONE_W;
                            if (last_word) begin
`ifdef CHECKSUM_EN
                                state_q <= S_CHECK;
`else
                                state_q     <= S_DONE;
                                rx_ready_q  <= 1'b0;
                                load_done_q <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef CHECKSUM_EN
                S_CHECK: begin
                    if (xfer) begin
                        if (rx_data != csum_q) begin
                            load_error_q <= 1'b1;
                        end
                        state_q     <= S_DONE;
                        rx_ready_q  <= 1'b0;
                        load_done_q <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    state_q     <= S_IDLE;
                    load_done_q <= 1'b0;
                    cpu_hold_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Instruction = instr_q;
    assign fetch_fault = fault_q;
    assign rx_ready    = rx_ready_q;
    assign cpu_hold    = cpu_hold_q;
    assign load_done   = load_done_q;
`ifdef CHECKSUM_EN
    assign load_error  = load_error_q;
`else
    assign load_error  = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Randomised bench for instruction_memory_loader against an array-based model of program memory.
// Honours CHECKSUM_EN the same way as the design.
module tb_instruction_memory_loader;

    localparam logic [31:0] NOP = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic        rd_en;
    logic [31:0] Instruction;
    logic        fetch_fault;
    logic        load_start;
    logic [8:0]  load_len;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    always #5 clk = ~clk;

    instruction_memory_loader #(.ADDR_WIDTH(8), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .Address(Address), .rd_en(rd_en),
        .Instruction(Instruction), .fetch_fault(fetch_fault),
        .load_start(load_start), .load_len(load_len),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
    );

    logic [31:0] model_mem [256];
    logic [7:0]  byte_q [$];
    logic [31:0] last_instr;
    logic        last_fault;
    logic        exp_err;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_random(input int unsigned words);
        for (int unsigned i = 0; i < words * 4; i++) byte_q.push_back(8'($urandom));
    endtask

    task automatic fetch_check(input logic [31:0] addr);
        Address = addr;
        rd_en   = 1'b1;
        tick();
        if (addr[31:10] != 0 || addr[1:0] != 0) begin
            last_instr = NOP;
            last_fault = 1'b1;
        end else begin
            last_instr = model_mem[addr[9:2]];
            last_fault = 1'b0;
        end
        check("fetch_instr", Instruction, last_instr);
        check("fetch_fault", {31'd0, fetch_fault}, {31'd0, last_fault});
    endtask

    task automatic hold_check();
        rd_en   = 1'b0;
        Address = $urandom;
        tick();
        check("hold_instr", Instruction, last_instr);
        check("hold_fault", {31'd0, fetch_fault}, {31'd0, last_fault});
    endtask

    task automatic do_load(input logic [8:0] len_field, input bit bad_csum, input bit poke);
        int unsigned n;
        logic [7:0]  b;
        logic [7:0]  x;
        logic [31:0] w;
        n = (int'(len_field) > 256) ? 256 : int'(len_field);
        x = 8'h00;
        Address    = $urandom;
        rd_en      = 1'b1;
        load_start = 1'b1;
        load_len   = len_field;
        tick();
        load_start = 1'b0;
        load_len   = 9'($urandom);
        check("ld_hold", {31'd0, cpu_hold}, 32'd1);
        check("ld_ready", {31'd0, rx_ready}, 32'd1);
        check("ld_err_clr", {31'd0, load_error}, 32'd0);
        for (int unsigned i = 0; i < n; i++) begin
            w = '0;
            for (int unsigned k = 0; k < 4; k++) begin
                b = byte_q.pop_front();
                repeat ($urandom_range(0, 2)) begin
                    rx_valid = 1'b0;
                    if (poke && $urandom_range(0, 3) == 0) begin
                        load_start = 1'b1;
                        load_len   = 9'($urandom_range(1, 300));
                    end
                    tick();
                    load_start = 1'b0;
                end
                rx_valid = 1'b1;
                rx_data  = b;
                tick();
                rx_valid = 1'b0;
                w = {w[23:0], b};
                x = x ^ b;
                if (!(i == n - 1 && k == 3)) begin
                    check("ld_busy_hold", {31'd0, cpu_hold}, 32'd1);
                    check("ld_busy_done", {31'd0, load_done}, 32'd0);
                    check("ld_gate_instr", Instruction, NOP);
                    check("ld_gate_fault", {31'd0, fetch_fault}, 32'd0);
                end
            end
            model_mem[i] = w;
        end
`ifdef CHECKSUM_EN
        check("ck_hold", {31'd0, cpu_hold}, 32'd1);
        check("ck_ready", {31'd0, rx_ready}, 32'd1);
        check("ck_done", {31'd0, load_done}, 32'd0);
        repeat ($urandom_range(0, 2)) tick();
        rx_valid = 1'b1;
        rx_data  = bad_csum ? (x ^ 8'h01) : x;
        tick();
        rx_valid = 1'b0;
        exp_err  = bad_csum;
`else
        exp_err  = 1'b0;
`endif
        check("done_pulse", {31'd0, load_done}, 32'd1);
        check("done_hold", {31'd0, cpu_hold}, 32'd1);
        check("done_ready", {31'd0, rx_ready}, 32'd0);
        check("done_err", {31'd0, load_error}, {31'd0, exp_err});
        tick();
        check("idle_done", {31'd0, load_done}, 32'd0);
        check("idle_hold", {31'd0, cpu_hold}, 32'd0);
        check("idle_instr", Instruction, NOP);
        last_instr = NOP;
        last_fault = 1'b0;
    endtask

    initial begin
        logic [7:0] rb [6];
        reset = 1'b1; Address = '0; rd_en = 1'b0; load_start = 1'b0; load_len = '0;
        rx_valid = 1'b0; rx_data = '0;
        repeat (3) tick();
        check("rst_instr", Instruction, NOP);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check("rst_ready", {31'd0, rx_ready}, 32'd0);
        check("rst_hold", {31'd0, cpu_hold}, 32'd0);
        check("rst_done", {31'd0, load_done}, 32'd0);
        check("rst_err", {31'd0, load_error}, 32'd0);
        reset = 1'b0;

        // Bytes offered while idle must be refused
        repeat (3) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            tick();
            check("idle_rx_ready", {31'd0, rx_ready}, 32'd0);
            check("idle_rx_hold", {31'd0, cpu_hold}, 32'd0);
        end
        rx_valid = 1'b0;

        // Oversized length clamps to full depth
        push_random(256);
        do_load(9'h1FF, 1'b0, 1'b1);
        fetch_check(32'h0);
        fetch_check(32'h3FC);

        byte_q = '{8'h20, 8'h09, 8'h00, 8'h01, 8'h23, 8'hbd, 8'hff, 8'hfc};
        do_load(9'd2, 1'b0, 1'b0);
        fetch_check(32'h0);
        fetch_check(32'h4);
        fetch_check(32'h8);

        fetch_check(32'h400);
        fetch_check(32'h2);
        fetch_check(32'h8000_0001);
        fetch_check(32'h0000_0C04);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) hold_check();
            else fetch_check({22'd0, 8'($urandom), 2'b00});
        end

        // Reset partway through a two-word load
        load_start = 1'b1;
        load_len   = 9'd2;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rb[i]    = 8'($urandom);
            rx_valid = 1'b1;
            rx_data  = rb[i];
            tick();
        end
        rx_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        check("mid_rst_hold", {31'd0, cpu_hold}, 32'd0);
        check("mid_rst_ready", {31'd0, rx_ready}, 32'd0);
        check("mid_rst_instr", Instruction, NOP);
        model_mem[0] = {rb[0], rb[1], rb[2], rb[3]};
        fetch_check(32'h0);
        fetch_check(32'h4);

        // Zero-length request is ignored
        load_start = 1'b1;
        load_len   = 9'd0;
        tick();
        load_start = 1'b0;
        check("zero_len_hold", {31'd0, cpu_hold}, 32'd0);
        check("zero_len_ready", {31'd0, rx_ready}, 32'd0);
        tick();
        check("zero_len_hold2", {31'd0, cpu_hold}, 32'd0);

        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load(9'd1, 1'b0, 1'b0);
        fetch_check(32'h0);
        byte_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_load(9'd1, 1'b1, 1'b0);
        fetch_check(32'h0);
        hold_check();
        check("err_sticky", {31'd0, load_error}, {31'd0, exp_err});

        for (int r = 0; r < 6; r++) begin
            int unsigned n;
            n = $urandom_range(1, 8);
            push_random(n);
            do_load(9'(n), 1'($urandom_range(0, 1)), 1'b1);
            for (int j = 0; j < 6; j++) fetch_check({22'd0, 8'($urandom_range(0, 9)), 2'b00});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete in time");
        $fatal(1);
    end

endmodule
